// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants.
package cpu_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : cpu_pkg

// File: rtl/register_file_if.sv
// Register file bus: write-back write port plus two operand read ports.
interface register_file_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
);

    logic              WriteEnable;
    logic [ADDR_W-1:0] WriteAddr;
    logic [WIDTH-1:0]  WriteData;
    logic              ReadEnA;
    logic [ADDR_W-1:0] ReadAddrA;
    logic [WIDTH-1:0]  ReadDataA;
    logic              ReadEnB;
    logic [ADDR_W-1:0] ReadAddrB;
    logic [WIDTH-1:0]  ReadDataB;

    modport master (
        output WriteEnable, WriteAddr, WriteData,
        output ReadEnA, ReadAddrA, ReadEnB, ReadAddrB,
        input  ReadDataA, ReadDataB
    );

    modport slave (
        input  WriteEnable, WriteAddr, WriteData,
        input  ReadEnA, ReadAddrA, ReadEnB, ReadAddrB,
        output ReadDataA, ReadDataB
    );

endinterface : register_file_if

// File: rtl/regfile_read_port.sv
// One registered read port: read mux, zero-register force, optional
// write-through forwarding (REGFILE_BYPASS_EN) and enabled output flop.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReadEn,
    input  logic [ADDR_W-1:0] ReadAddr,
    input  logic [WIDTH-1:0]  storage [DEPTH],
`ifdef REGFILE_BYPASS_EN
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [WIDTH-1:0]  WriteData,
`endif
    output logic [WIDTH-1:0]  ReadData
);

    logic [WIDTH-1:0] rd_word_c;

    // Select the word to capture; r0 always reads as zero, even when forwarded.
    always_comb begin
        rd_word_c = '0;
        if (ReadAddr != ADDR_W'(ZERO_REG)) begin
            rd_word_c = storage[ReadAddr];
`ifdef REGFILE_BYPASS_EN
            if (WriteEnable && (WriteAddr == ReadAddr)) begin
                rd_word_c = WriteData;
            end
`endif
        end
    end

    // Output register: captures on enabled edges, otherwise holds.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ReadData <= '0;
        end else if (ReadEn) begin
            ReadData <= rd_word_c;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// General-purpose register file: one write port, two registered read ports,
// register 0 hardwired to zero. Optional macro REGFILE_BYPASS_EN enables
// same-edge write-through forwarding to the read ports.
module register_file
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    register_file_if.slave  bus
);

    logic [WIDTH-1:0] storage [DEPTH];

    // Storage array write; writes to r0 are discarded so word 0 stays zero.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (bus.WriteEnable && (bus.WriteAddr != ADDR_W'(ZERO_REG))) begin
            storage[bus.WriteAddr] <= bus.WriteData;
        end
    end

    regfile_read_port #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_port_a (
        .Clk         (Clk),
        .Rst         (Rst),
        .ReadEn      (bus.ReadEnA),
        .ReadAddr    (bus.ReadAddrA),
        .storage     (storage),
`ifdef REGFILE_BYPASS_EN
        .WriteEnable (bus.WriteEnable),
        .WriteAddr   (bus.WriteAddr),
        .WriteData   (bus.WriteData),
`endif
        .ReadData    (bus.ReadDataA)
    );

    regfile_read_port #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_port_b (
        .Clk         (Clk),
        .Rst         (Rst),
        .ReadEn      (bus.ReadEnB),
        .ReadAddr    (bus.ReadAddrB),
        .storage     (storage),
`ifdef REGFILE_BYPASS_EN
        .WriteEnable (bus.WriteEnable),
        .WriteAddr   (bus.WriteAddr),
        .WriteData   (bus.WriteData),
`endif
        .ReadData    (bus.ReadDataB)
    );

endmodule : register_file
